// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side bundle for the 8:1 round-robin arbiter; lock exists only with MUX8_ARB_LOCK_EN.
// master = requester/driver side, slave = arbiter side.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] d_in;
`ifdef MUX8_ARB_LOCK_EN
  logic       lock;
`endif
  logic [2:0] sel;
  logic [7:0] grant;
  logic       gnt_valid;
  logic       d_out;

  modport master (
    output req, d_in,
`ifdef MUX8_ARB_LOCK_EN
    output lock,
`endif
    input  sel, grant, gnt_valid, d_out
  );

  modport slave (
    input  req, d_in,
`ifdef MUX8_ARB_LOCK_EN
    input  lock,
`endif
    output sel, grant, gnt_valid, d_out
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select; optional grant lock via MUX8_ARB_LOCK_EN.
// Latency: request sampled at edge N is granted after edge N; d_out is combinational from d_in.
// Backpressure: a requester keeps the grant while asserting req, up to HOLD_MAX cycles (unless locked).
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mux8_rr_arbiter_if.slave bus
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] sel_q;
  logic [7:0] grant_q;
  logic       vld_q;
  logic [7:0] hold_cnt;

  logic       lock_hold;
  logic [2:0] arb_start;
  logic       arb_hit;
  logic [2:0] arb_idx;
  logic       keep;

  // Scan a full lap starting at 'start'; lowest offset from start wins.
  function automatic logic [3:0] arb(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX8_ARB_LOCK_EN
  assign lock_hold = bus.lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign arb_start          = (state == BUSY) ? sel_q + 3'd1 : ptr;
  assign {arb_hit, arb_idx} = arb(bus.req, arb_start);
  assign keep               = bus.req[sel_q] && ((hold_cnt < HOLD_LIM) || lock_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel_q    <= 3'd0;
      grant_q  <= 8'd0;
      vld_q    <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            sel_q    <= arb_idx;
            grant_q  <= 8'd1 << arb_idx;
            vld_q    <= 1'b1;
            hold_cnt <= 8'd1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (keep) begin
            // Saturates at the limit while locked.
            if (hold_cnt < HOLD_LIM) hold_cnt <= hold_cnt + 8'd1;
          end else begin
            ptr <= sel_q + 3'd1;
            if (arb_hit) begin
              sel_q    <= arb_idx;
              grant_q  <= 8'd1 << arb_idx;
              hold_cnt <= 8'd1;
            end else begin
              grant_q <= 8'd0;
              vld_q   <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.gnt_valid = vld_q;
  assign bus.d_out     = vld_q & bus.d_in[sel_q];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Three arbiters (HOLD_MAX 8, 1, 2) on shared random/directed stimulus, checked each cycle
// against an integer model of the round-robin rules plus literal expectations.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] d_in;
  logic       lock;

  int checks;
  int errors;
  bit chk_on;

  mux8_rr_arbiter_if if8 ();
  mux8_rr_arbiter_if if1 ();
  mux8_rr_arbiter_if if2 ();

  assign if8.req = req;  assign if8.d_in = d_in;
  assign if1.req = req;  assign if1.d_in = d_in;
  assign if2.req = req;  assign if2.d_in = d_in;
`ifdef MUX8_ARB_LOCK_EN
  assign if8.lock = lock;
  assign if1.lock = lock;
  assign if2.lock = lock;
`endif

  mux8_rr_arbiter #(.HOLD_MAX(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  mux8_rr_arbiter #(.HOLD_MAX(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mux8_rr_arbiter #(.HOLD_MAX(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index, hold count and pointer as plain integers.
  int hm[3] = '{8, 1, 2};
  int m_sel[3];
  int m_cnt[3];
  int m_ptr[3];
  bit m_busy[3];

  function automatic int first_req(input logic [7:0] r, input int start);
    for (int i = 0; i < 8; i++)
      if (r[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction

  function automatic bit lock_eff();
`ifdef MUX8_ARB_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0; m_busy[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0; m_busy[k] = 0;
        end else if (!m_busy[k]) begin
          if (req != 8'd0) begin
            m_sel[k]  = first_req(req, m_ptr[k]);
            m_cnt[k]  = 1;
            m_busy[k] = 1;
          end
        end else if (req[m_sel[k]] && (m_cnt[k] < hm[k] || lock_eff())) begin
          if (m_cnt[k] < hm[k]) m_cnt[k]++;
        end else begin
          int w;
          m_ptr[k] = (m_sel[k] + 1) % 8;
          w = first_req(req, m_ptr[k]);
          if (w >= 0) begin
            m_sel[k] = w;
            m_cnt[k] = 1;
          end else begin
            m_busy[k] = 0;
          end
        end
      end
    end
  end

  task automatic cmp(input int k, input logic [2:0] s, input logic [7:0] g,
                     input logic v, input logic d);
    logic [7:0] eg;
    logic       ed;
    eg = m_busy[k] ? 8'(1 << m_sel[k]) : 8'd0;
    ed = m_busy[k] ? d_in[m_sel[k]] : 1'b0;
    chk($sformatf("model_sel_%0d", hm[k]),   32'(s), 32'(m_sel[k]));
    chk($sformatf("model_grant_%0d", hm[k]), 32'(g), 32'(eg));
    chk($sformatf("model_valid_%0d", hm[k]), 32'(v), 32'(m_busy[k]));
    chk($sformatf("model_dout_%0d", hm[k]),  32'(d), 32'(ed));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        cmp(0, if8.sel, if8.grant, if8.gnt_valid, if8.d_out);
        cmp(1, if1.sel, if1.grant, if1.gnt_valid, if1.d_out);
        cmp(2, if2.sel, if2.grant, if2.gnt_valid, if2.d_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_on = 1'b0;
    req    = 8'd0;
    d_in   = 8'd0;
    lock   = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_grant", 32'(if8.grant), 32'h0);
      chk("idle_valid", 32'(if8.gnt_valid), 32'h0);
      chk("idle_sel", 32'(if8.sel), 32'h0);
      chk("idle_dout", 32'(if8.d_out), 32'h0);
    end

    // Single requester 2, expiry at 8 re-grants with no bubble.
    req  = 8'b0000_0100;
    d_in = 8'b0000_0100;
    tick();
    chk("single_sel", 32'(if8.sel), 32'd2);
    chk("single_grant", 32'(if8.grant), 32'h04);
    chk("single_dout", 32'(if8.d_out), 32'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("expiry_valid", 32'(if8.gnt_valid), 32'd1);
      chk("expiry_sel", 32'(if8.sel), 32'd2);
    end

    // HOLD_MAX=1 rotation with everyone requesting.
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rotate_sel", 32'(if1.sel), 32'(i % 8));
      chk("rotate_valid", 32'(if1.gnt_valid), 32'd1);
    end

    // Owner 6 drops; wrap order 7 then 1.
    do_reset();
    req = 8'h40;
    tick();
    chk("own6_sel", 32'(if8.sel), 32'd6);
    req = 8'h82;
    tick();
    chk("wrap_sel7", 32'(if8.sel), 32'd7);
    req = 8'h02;
    tick();
    chk("wrap_sel1", 32'(if8.sel), 32'd1);

    // Asynchronous reset mid-grant of 5.
    do_reset();
    req = 8'h20;
    tick();
    chk("pre_rst_sel", 32'(if8.sel), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(if8.grant), 32'h0);
    chk("async_valid", 32'(if8.gnt_valid), 32'h0);
    req = 8'h21;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel", 32'(if8.sel), 32'd0);
    chk("post_rst_grant", 32'(if8.grant), 32'h01);

    // Lock behaviour on HOLD_MAX=2.
    do_reset();
    req = 8'h03;
`ifdef MUX8_ARB_LOCK_EN
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lock_hold_sel", 32'(if2.sel), 32'd0);
    end
    lock = 1'b0;
    tick();
    chk("lock_rel_sel", 32'(if2.sel), 32'd1);
`else
    tick();
    chk("nolock_sel_a", 32'(if2.sel), 32'd0);
    tick();
    chk("nolock_sel_b", 32'(if2.sel), 32'd0);
    tick();
    chk("nolock_sel_c", 32'(if2.sel), 32'd1);
`endif

    // Random traffic checked by the model each cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) req = 8'($urandom);
      if ($urandom_range(9) == 0) req = 8'd0;
      d_in = 8'($urandom);
      if ($urandom_range(15) == 0) lock = ~lock;
      if ($urandom_range(199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    lock  = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
